simple_fifo_arbiter: RTL and testbench

Round-robin write arbiter that shares one `simple_fifo` instance among `num_req` requesters in the S1 bridge path. Each requester presents valid/data. The arbiter grants one requester per cycle, drives the FIFO write strobe, and prepends the requester ID to the stored word. It tracks FIFO occupancy with its own credit counter rather than trusting the FIFO status flags, and flags any read while empty as a sticky error.

---
 rtl/simple_fifo_arb_pkg.sv | 13 +
 rtl/simple_fifo_arbiter_rr_pick.sv | 36 +++
 rtl/simple_fifo_arbiter.sv | 129 ++++++++++++
 tb/tb_simple_fifo_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package simple_fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/simple_fifo_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Walk from the farthest offset back to start so the nearest request wins last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start_i) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IDX_W'(pos);
      if (req_i[pos_idx]) begin
        gnt_o          = '0;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_fifo_arbiter.sv
// Round-robin write arbiter in front of a shared FIFO, with its own occupancy credit counter.
// Optional burst lock enabled by defining SIMPLE_FIFO_ARB_BURST_LOCK_EN.
module simple_fifo_arbiter
  import simple_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                     sys_clock_i,
  input  logic                                     sys_reset_i,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]                req_data_i,
`ifdef SIMPLE_FIFO_ARB_BURST_LOCK_EN
  input  logic [NUM_REQ-1:0]                       req_last_i,
`endif
  output logic [NUM_REQ-1:0]                       req_ready_o,
  output logic                                     fifo_write_o,
  output logic [id_width(NUM_REQ)+DATA_W-1:0]      fifo_data_o,
  input  logic                                     fifo_read_i,
  output logic [$clog2(FIFO_DEPTH):0]              level_o,
  output logic                                     err_underflow_o
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_e        state_q;
  logic [ID_W-1:0]   lock_id_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] last_w;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic [ID_W-1:0]    sel_idx;
  logic               pick_any;
  logic               space_ok;
  logic               wr;

`ifdef SIMPLE_FIFO_ARB_BURST_LOCK_EN
  assign last_w = req_last_i;
`else
  // Every beat is its own burst, so the lock state is never entered.
  assign last_w = '1;
`endif

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + ID_W'(1);
  endfunction

  // While locked only the burst owner is visible to the picker.
  always_comb begin
    req_masked = req_valid_i;
    if (state_q == ST_LOCK) begin
      req_masked            = '0;
      req_masked[lock_id_q] = req_valid_i[lock_id_q];
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req_i   (req_masked),
    .start_i (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Space is judged on the registered level only; a same-cycle read never frees a slot.
  assign space_ok     = (level_q < LVL_W'(FIFO_DEPTH));
  assign wr           = sys_reset_i && space_ok && pick_any;
  assign req_ready_o  = wr ? pick_gnt : '0;
  assign fifo_write_o = wr;
  assign sel_idx      = wr ? pick_idx : rr_ptr_q;
  assign fifo_data_o  = {sel_idx, req_data_i[int'(sel_idx)*DATA_W +: DATA_W]};

  always_comb begin
    level_d = level_q;
    err_d   = err_q;
    if (fifo_read_i && (level_q == '0)) err_d = 1'b1;
    if (wr && !fifo_read_i) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wr && fifo_read_i && (level_q != '0)) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_i) begin
      state_q   <= ST_IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      level_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      level_q <= level_d;
      err_q   <= err_d;
      if (wr) begin
        case (state_q)
          ST_IDLE: begin
            if (!last_w[pick_idx]) begin
              state_q   <= ST_LOCK;
              lock_id_q <= pick_idx;
            end else begin
              rr_ptr_q <= ptr_inc(pick_idx);
            end
          end
          ST_LOCK: begin
            if (last_w[pick_idx]) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= ptr_inc(pick_idx);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign level_o         = level_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_simple_fifo_arbiter.sv
// Randomized and directed bench for simple_fifo_arbiter against a behavioural reference model.
module tb_simple_fifo_arbiter;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;
  localparam int LW    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      valid;
  logic [N-1:0]      last;
  logic [N*DW-1:0]   data;
  logic              rd;
  logic [N-1:0]      ready;
  logic              fwr;
  logic [IDW+DW-1:0] fdata;
  logic [LW-1:0]     level;
  logic              err;

  always #5 clk = ~clk;

  simple_fifo_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clock_i     (clk),
    .sys_reset_i     (rst_n),
    .req_valid_i     (valid),
    .req_data_i      (data),
`ifdef SIMPLE_FIFO_ARB_BURST_LOCK_EN
    .req_last_i      (last),
`endif
    .req_ready_o     (ready),
    .fifo_write_o    (fwr),
    .fifo_data_o     (fdata),
    .fifo_read_i     (rd),
    .level_o         (level),
    .err_underflow_o (err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int ptr_m     = 0;
  int level_m   = 0;
  int lock_id_m = 0;
  bit lock_m    = 0;
  bit err_m     = 0;

  // Observations from the latest cycle
  logic [N-1:0]      obs_rdy;
  logic [IDW+DW-1:0] obs_data;
  int                obs_win;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int                win;
    bit                exp_wr;
    logic [N-1:0]      exp_rdy;
    logic [IDW-1:0]    w2;
    @(negedge clk);
    win = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr_m + k) % N;
      if (win < 0 && valid[i] && (!lock_m || i == lock_id_m)) win = i;
    end
    exp_wr  = rst_n && (win >= 0) && (level_m < DEPTH);
    exp_rdy = '0;
    if (exp_wr) exp_rdy[win] = 1'b1;
    obs_rdy  = ready;
    obs_data = fdata;
    obs_win  = -1;
    for (int i = 0; i < N; i++) if (ready[i]) obs_win = i;
    chk("ready", ready, exp_rdy);
    chk("write", fwr, exp_wr);
    if (exp_wr) begin
      w2 = win[IDW-1:0];
      chk("data", fdata, {w2, data[win*DW +: DW]});
    end
    chk("level", level, level_m);
    chk("err", err, err_m);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      ptr_m = 0; level_m = 0; lock_m = 0; lock_id_m = 0; err_m = 0;
    end else begin
      if (rd && level_m == 0) err_m = 1;
      if (exp_wr && !rd) level_m++;
      else if (rd && !exp_wr && level_m > 0) level_m--;
      if (exp_wr) begin
`ifdef SIMPLE_FIFO_ARB_BURST_LOCK_EN
        if (!lock_m && !last[win]) begin
          lock_m = 1; lock_id_m = win;
        end else if (lock_m && last[win]) begin
          lock_m = 0; ptr_m = (win + 1) % N;
        end else if (!lock_m) begin
          ptr_m = (win + 1) % N;
        end
`else
        ptr_m = (win + 1) % N;
`endif
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain_to(input int target);
    valid = '0;
    rd    = 1'b1;
    for (int g = 0; g < 20 && level_m > target; g++) cycle();
    rd = 1'b0;
    chk("drain_level", level, target);
  endtask

  initial begin
    logic [DW-1:0] pay [3];
    pay[0] = 64'hA; pay[1] = 64'hB; pay[2] = 64'hC;

    rst_n = 1'b0;
    valid = '1;
    last  = '1;
    rd    = 1'b0;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = {$urandom, $urandom};
    @(posedge clk);
    #1;

    // Reset holds readies and write low even with all requesters valid
    cycle();
    cycle();
    chk("reset_ready", obs_rdy, 0);
    rst_n = 1'b1;

    // Single requester, three beats
    valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      data[2*DW +: DW] = pay[k];
      cycle();
      chk("single_data", obs_data, {2'd2, pay[k]});
      chk("single_level", level, k + 1);
    end
    drain_to(0);

    // Fairness: all valid, reads on alternate cycles
    do_reset();
    valid = '1;
    for (int k = 0; k < 12; k++) begin
      rd = (k % 2 == 1);
      cycle();
      chk("fair_order", obs_win, k % 4);
    end
    rd = 1'b0;

    // Fill to full
    for (int g = 0; g < 20 && level_m < DEPTH; g++) cycle();
    chk("full_level", level, DEPTH);
    cycle();
    chk("full_ready", obs_rdy, 0);
    rd = 1'b1;
    cycle();
    chk("full_read_ready", obs_rdy, 0);
    rd = 1'b0;
    chk("after_read_level", level, DEPTH - 1);
    cycle();
    chk("resume_grant", obs_rdy != 0, 1);

    // Simultaneous write and read at level 5
    drain_to(5);
    valid = 4'b0001;
    rd    = 1'b1;
    cycle();
    chk("simul_write", obs_rdy, 4'b0001);
    chk("simul_level", level, 5);

    // Underflow
    drain_to(0);
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    chk("uflow_err", err, 1);
    chk("uflow_level", level, 0);
    do_reset();
    chk("uflow_cleared", err, 0);

`ifdef SIMPLE_FIFO_ARB_BURST_LOCK_EN
    // Burst lock: req1 holds the grant across a gap until its last beat
    begin
      logic [N-1:0] bv [5];
      logic [N-1:0] bl [5];
      int           ew [5];
      bv[0] = 4'b0011; bl[0] = 4'b0001; ew[0] = 1;
      bv[1] = 4'b0001; bl[1] = 4'b0001; ew[1] = -1;
      bv[2] = 4'b0011; bl[2] = 4'b0001; ew[2] = 1;
      bv[3] = 4'b0011; bl[3] = 4'b0011; ew[3] = 1;
      bv[4] = 4'b0001; bl[4] = 4'b0001; ew[4] = 0;
      valid = 4'b0001;
      last  = 4'b0001;
      cycle();
      for (int k = 0; k < 5; k++) begin
        valid = bv[k];
        last  = bl[k];
        cycle();
        chk("burst_grant", obs_win, ew[k]);
      end
      drain_to(0);
    end
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      valid = N'($urandom);
      last  = N'($urandom);
      rd    = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 60) != 0);
      for (int i = 0; i < N; i++) data[i*DW +: DW] = {$urandom, $urandom};
      cycle();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
